pce_line_doubler: RTL

Scan-rate doubler that sits directly downstream of the HuC6260 VCE. It captures each 15 kHz line of 9-bit RGB pixels, strobed by the VCE pixel clock enable, into one half of a two-bank line buffer. While the next line is being captured, it replays the previous line twice at double line rate with regenerated syncs, producing a 31 kHz stream for the VGA output stage.

---
 rtl/pce_line_doubler_if.sv | 27 ++
 rtl/pce_line_doubler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pce_line_doubler_if.sv
// Video bundle between the VCE-side source and the line doubler.
// The master drives captured pixels and syncs; the slave returns the 31 kHz stream.
interface pce_line_doubler_if;
  logic       pix_en;
  logic [2:0] pix_r;
  logic [2:0] pix_g;
  logic [2:0] pix_b;
  logic       hsyn_n;
  logic       vsyn_n;
  logic [2:0] out_r;
  logic [2:0] out_g;
  logic [2:0] out_b;
  logic       out_de;
  logic       out_en;
  logic       out_hsync_n;
  logic       out_vsync_n;

  modport master (
    output pix_en, pix_r, pix_g, pix_b, hsyn_n, vsyn_n,
    input  out_r, out_g, out_b, out_de, out_en, out_hsync_n, out_vsync_n
  );

  modport slave (
    input  pix_en, pix_r, pix_g, pix_b, hsyn_n, vsyn_n,
    output out_r, out_g, out_b, out_de, out_en, out_hsync_n, out_vsync_n
  );
endinterface

// File: rtl/pce_line_doubler.sv
// 15 kHz to 31 kHz scan doubler: captures one line into a ping-pong buffer while
// replaying the previous line twice with regenerated syncs.
module pce_line_doubler #(
  parameter int LINE_W  = 512,
  parameter int ADDR_W  = 9,
  parameter int CNT_W   = 12,
  parameter int OUT_DIV = 2,
  parameter int HS_LEN  = 96,
  parameter int H_START = 144
) (
  input  logic              i_clock,
  input  logic              i_reset,
  pce_line_doubler_if.slave io_vid
);

  typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_hs_d;
  logic                r_vs_d;
  logic                w_hs_edge;
  logic                r_seen_edge;
  logic                r_valid;
  logic                r_wr_bank;
  logic [ADDR_W:0]     r_wr_addr;
  logic [ADDR_W:0]     w_wr_addr_inc;
  logic                w_wr_ok;
  logic [ADDR_W:0]     r_len [2];
  logic [ADDR_W:0]     w_rd_len;
  logic                w_rd_bank;
  logic [CNT_W-1:0]    r_per_cnt;
  logic [CNT_W:0]      r_period;
  logic [CNT_W-1:0]    w_half;
  logic [CNT_W-1:0]    r_ocnt;
  logic [CNT_W-1:0]    w_ocnt_next;
  logic [CNT_W-1:0]    w_ocnt_rel;
  logic [ADDR_W:0]     r_rd_addr;
  logic [ADDR_W:0]     w_rd_addr_next;
  logic                w_in_pass;
  logic                w_pulse;
  logic [ADDR_W:0]     w_rd_idx;
  logic [8:0]          r_mem [2*LINE_W];
  logic [8:0]          r_pix;
  logic                r_de;
  logic                r_hsync_n;
  logic                r_vsync_n;

  assign w_hs_edge     = r_hs_d & ~io_vid.hsyn_n;
  assign w_wr_ok       = io_vid.pix_en && (r_wr_addr < (ADDR_W+1)'(LINE_W));
  assign w_wr_addr_inc = r_wr_addr + (ADDR_W+1)'(w_wr_ok);
  assign w_rd_bank     = ~r_wr_bank;
  assign w_rd_len      = r_len[w_rd_bank];
  assign w_rd_idx      = {w_rd_bank, r_rd_addr[ADDR_W-1:0]};
  assign w_half        = r_period[CNT_W:1];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_hs_d      <= 1'b0;
      r_vs_d      <= 1'b1;
      r_seen_edge <= 1'b0;
      r_valid     <= 1'b0;
      r_per_cnt   <= '0;
      r_period    <= '0;
      r_wr_bank   <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_hs_d <= io_vid.hsyn_n;
      r_vs_d <= io_vid.vsyn_n;
      if (w_hs_edge) begin
        r_seen_edge <= 1'b1;
        r_valid     <= r_valid | r_seen_edge;
        r_per_cnt   <= '0;
        r_period    <= {1'b0, r_per_cnt} + (CNT_W+1)'(1);
        r_wr_bank   <= ~r_wr_bank;
        r_wr_addr   <= '0;
      end else begin
        if (r_per_cnt != {CNT_W{1'b1}}) r_per_cnt <= r_per_cnt + CNT_W'(1);
        r_wr_addr <= w_wr_addr_inc;
      end
    end
  end

  // Length recorded includes a pixel arriving on the swap cycle itself.
  for (genvar gi = 0; gi < 2; gi++) begin : g_len
    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_len[gi] <= '0;
      else if (w_hs_edge && (r_wr_bank == 1'(gi))) r_len[gi] <= w_wr_addr_inc;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_wr_ok)
      r_mem[{r_wr_bank, r_wr_addr[ADDR_W-1:0]}] <= {io_vid.pix_g, io_vid.pix_r, io_vid.pix_b};
  end

  assign w_in_pass  = (r_state != IDLE);
  assign w_ocnt_rel = r_ocnt - CNT_W'(H_START);
  assign w_pulse    = w_in_pass && (r_ocnt >= CNT_W'(H_START)) &&
                      ((w_ocnt_rel % CNT_W'(OUT_DIV)) == '0) && (r_rd_addr < w_rd_len);

  always_comb begin
    w_state_next   = r_state;
    w_ocnt_next    = r_ocnt;
    w_rd_addr_next = r_rd_addr + (ADDR_W+1)'(w_pulse);
    case (r_state)
      PASS0: begin
        if (r_ocnt == w_half - CNT_W'(1)) begin
          w_state_next   = PASS1;
          w_ocnt_next    = '0;
          w_rd_addr_next = '0;
        end else begin
          w_ocnt_next = r_ocnt + CNT_W'(1);
        end
      end
      PASS1: begin
        if (r_ocnt != {CNT_W{1'b1}}) w_ocnt_next = r_ocnt + CNT_W'(1);
      end
      default: w_rd_addr_next = '0;
    endcase
    // Any line edge resynchronises the output, even mid-pass.
    if (w_hs_edge && (r_valid || r_seen_edge)) begin
      w_state_next   = PASS0;
      w_ocnt_next    = '0;
      w_rd_addr_next = '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_ocnt    <= '0;
      r_rd_addr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ocnt    <= w_ocnt_next;
      r_rd_addr <= w_rd_addr_next;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pix     <= '0;
      r_de      <= 1'b0;
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
    end else begin
      r_pix     <= w_pulse ? r_mem[w_rd_idx] : 9'd0;
      r_de      <= w_pulse;
      r_hsync_n <= !(w_in_pass && (r_ocnt < CNT_W'(HS_LEN)));
      if (w_in_pass && (r_ocnt == '0)) r_vsync_n <= r_vs_d;
    end
  end

  assign io_vid.out_g       = r_pix[8:6];
  assign io_vid.out_r       = r_pix[5:3];
  assign io_vid.out_b       = r_pix[2:0];
  assign io_vid.out_de      = r_de;
  assign io_vid.out_en      = r_de;
  assign io_vid.out_hsync_n = r_hsync_n;
  assign io_vid.out_vsync_n = r_vsync_n;

endmodule
